bram_capture_ctrl: RTL and testbench

- Sequences the receiver's sample stream (valid/datos) into a shared dual-bank BRAM using a ping-pong scheme. The PS reads the BRAM through its other port.
- Per bank: the controller fills the sample words, writes a nonzero flag word, then pulses irq. The PS releases the bank by writing 0 to the flag.
- Before refilling a bank, the controller reads its flag back through bram_dout. Samples arriving while the next bank is still owned by the PS are dropped and counted.

---
 rtl/bram_capture_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_bram_capture_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_capture_ctrl.sv
// bram_capture_ctrl
//   Writes the receiver sample stream into a two-bank BRAM, one bank at a
//   time (ping-pong). Each bank is filled with DEPTH samples, closed with a
//   nonzero flag word, and announced with a one-cycle irq. The PS hands a
//   bank back by writing 0 to its flag. Before refilling a bank the
//   controller reads the flag back. Samples that arrive while the
//   controller cannot take them are dropped and counted.
//
//   Bank b layout (byte addresses): base(b) = b*(DEPTH+1)*4
//     base(b) + 0          flag word
//     base(b) + 4*(k+1)    sample k, k = 0..DEPTH-1
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   run          capture enable level; dropping it aborts to IDLE
//   valid        one-cycle sample strobe
//   datos        sample word, qualified by valid
//   bram_dout    BRAM read data (1-cycle read latency)
//   bram_en      BRAM enable
//   bram_we      BRAM write enable
//   bram_addr    BRAM byte address (word aligned)
//   bram_din     BRAM write data
//   irq          one-cycle pulse after a bank's flag is written
//   bank         bank currently targeted
//   busy         controller is not IDLE
//   frame_cnt    completed banks (wraps)
//   overrun_cnt  dropped samples (saturates)
module bram_capture_ctrl #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int DEPTH         = 1024,
  parameter int POLL_INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              valid,
  input  logic [DATA_W-1:0] datos,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              irq,
  output logic              bank,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       overrun_cnt
);

  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int PCNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

  localparam logic [ADDR_W-1:0] BANK_SPAN = ADDR_W'((DEPTH + 1) * 4);
  localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(DEPTH);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_RD,
    STALL,
    CAPTURE,
    FLAG
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;        // samples already written into the current bank
  logic [PCNT_W-1:0] poll_cnt;
  logic              drop;
  logic [15:0]       frame_next;

  function automatic logic [ADDR_W-1:0] bank_base(input logic b);
    return b ? BANK_SPAN : '0;
  endfunction

  function automatic logic [ADDR_W-1:0] sample_addr(input logic b,
                                                     input logic [IDX_W-1:0] k);
    return bank_base(b) + ((ADDR_W'(k) + ADDR_W'(1)) << 2);
  endfunction

  function automatic logic [DATA_W-1:0] flag_word(input logic [15:0] f);
    logic [31:0] w;
    w = {1'b1, 15'd0, f};
    return DATA_W'(w);
  endfunction

  // A strobe is lost whenever the controller is busy but not accepting
  // samples. The cycle right after the last write of a bank is still
  // CAPTURE; sources never strobe there, so it is not treated as a drop.
  always_comb begin
    drop       = valid && ((state == CHECK) || (state == WAIT_RD) ||
                           (state == STALL) || (state == FLAG));
    frame_next = frame_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      poll_cnt    <= '0;
      bram_en     <= 1'b0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      irq         <= 1'b0;
      bank        <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      overrun_cnt <= '0;
    end else begin
      // Bus strobes and irq are single-cycle unless a state re-asserts them.
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      irq     <= 1'b0;

      if (drop && (overrun_cnt != 16'hFFFF)) begin
        overrun_cnt <= overrun_cnt + 16'd1;
      end

      // The flag word is already on the bus during FLAG, so the bank is
      // closed even if run falls in that same cycle.
      if (state == FLAG) begin
        frame_cnt <= frame_next;
        irq       <= 1'b1;
        bank      <= ~bank;
      end

      if ((state != IDLE) && !run) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (run) begin
              state     <= CHECK;
              busy      <= 1'b1;
              bram_en   <= 1'b1;
              bram_addr <= bank_base(bank);
            end
          end

          // Read is on the bus during CHECK; its data is valid in WAIT_RD.
          CHECK: begin
            state <= WAIT_RD;
          end

          WAIT_RD: begin
            if (bram_dout == '0) begin
              state <= CAPTURE;
              idx   <= '0;
            end else begin
              state    <= STALL;
              poll_cnt <= '0;
            end
          end

          STALL: begin
            if (poll_cnt == POLL_LAST) begin
              state     <= CHECK;
              bram_en   <= 1'b1;
              bram_addr <= bank_base(bank);
            end else begin
              poll_cnt <= poll_cnt + PCNT_W'(1);
            end
          end

          // idx == IDX_FULL means the last sample's write is on the bus now;
          // the flag goes out on the next cycle.
          CAPTURE: begin
            if (idx == IDX_FULL) begin
              state     <= FLAG;
              bram_en   <= 1'b1;
              bram_we   <= 1'b1;
              bram_addr <= bank_base(bank);
              bram_din  <= flag_word(frame_next);
            end else if (valid) begin
              bram_en   <= 1'b1;
              bram_we   <= 1'b1;
              bram_addr <= sample_addr(bank, idx);
              bram_din  <= datos;
              idx       <= idx + IDX_W'(1);
            end
          end

          // Flag check of the other bank goes out alongside irq.
          FLAG: begin
            state     <= CHECK;
            bram_en   <= 1'b1;
            bram_addr <= bank_base(~bank);
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Testbench for bram_capture_ctrl (DEPTH=4, POLL_INTERVAL=4).
// The bench owns a BRAM model and a PS model that releases flags. A
// time-stamped behavioural model predicts every bus cycle, irq, bank and
// counter; a directed sequence is followed by randomized traffic.
module tb_bram_capture_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam int POLL   = 4;
  localparam int WORDS  = 2 * (DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] datos = '0;
  logic [DATA_W-1:0] bram_dout = '0;
  logic              bram_en, bram_we, irq, bank, busy;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic [15:0]       frame_cnt, overrun_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bram_capture_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .POLL_INTERVAL(POLL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .valid(valid), .datos(datos),
    .bram_dout(bram_dout), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .irq(irq), .bank(bank),
    .busy(busy), .frame_cnt(frame_cnt), .overrun_cnt(overrun_cnt)
  );

  // BRAM / PS model state
  logic [DATA_W-1:0] mem [WORDS];
  int rel_word = 0;
  int rel_req  = 0;
  int rel_ack  = 0;
  bit ps_random = 0;

  // Behavioural model: expected outputs for the cycle after 'cyc'
  int cyc = 0;
  bit m_busy, m_cap, m_bank;
  int m_n, m_read_at, m_flag_at, m_frame, m_over;
  bit e_en, e_we, e_irq, e_busy;
  logic [31:0] e_addr, e_din;

  function automatic logic [31:0] base(input bit b);
    return b ? 32'((DEPTH + 1) * 4) : 32'd0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_cap = 0; m_bank = 0; m_n = 0;
    m_read_at = -1; m_flag_at = -1; m_frame = 0; m_over = 0;
    e_en = 0; e_we = 0; e_irq = 0; e_busy = 0; e_addr = '0; e_din = '0;
  endtask

  task automatic model_step();
    bit flag_now;
    e_en = 0; e_we = 0; e_irq = 0;
    if (!m_busy) begin
      if (run) begin
        m_busy = 1; m_cap = 0; m_flag_at = -1;
        m_read_at = cyc + 1;
        e_en = 1; e_addr = base(m_bank);
      end
    end else begin
      if (valid && !m_cap && m_over < 65535) m_over++;
      flag_now = (cyc == m_flag_at);
      if (flag_now) begin
        m_frame = (m_frame + 1) % 65536;
        e_irq = 1;
        m_bank = ~m_bank;
        m_flag_at = -1;
      end
      if (!run) begin
        m_busy = 0; m_cap = 0; m_read_at = -1;
      end else if (flag_now) begin
        m_read_at = cyc + 1;
        e_en = 1; e_addr = base(m_bank);
      end else if (cyc == m_read_at + 1) begin
        if (bram_dout == '0) begin
          m_cap = 1; m_n = 0;
        end else begin
          m_read_at = cyc + 1 + POLL;
        end
      end else if (cyc + 1 == m_read_at) begin
        e_en = 1; e_addr = base(m_bank);
      end else if (m_cap) begin
        if (m_n == DEPTH) begin
          m_cap = 0; m_flag_at = cyc + 1;
          e_en = 1; e_we = 1; e_addr = base(m_bank);
          e_din = {1'b1, 15'd0, 16'(m_frame + 1)};
        end else if (valid) begin
          e_en = 1; e_we = 1;
          e_addr = base(m_bank) + 32'(4 * (m_n + 1));
          e_din = datos;
          m_n++;
        end
      end
    end
    e_busy = m_busy;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      for (int i = 0; i < WORDS; i++) mem[i] = '0;
    end else begin
      model_step();
      if (bram_en && (int'(bram_addr >> 2) < WORDS)) begin
        if (bram_we) mem[int'(bram_addr >> 2)] = bram_din;
        else bram_dout <= mem[int'(bram_addr >> 2)];
      end
      if (rel_req != rel_ack) begin
        mem[rel_word] = '0;
        rel_ack = rel_req;
      end
      if (ps_random) begin
        for (int b = 0; b < 2; b++) begin
          if (mem[b * (DEPTH + 1)] != '0 && $urandom_range(0, 15) == 0)
            mem[b * (DEPTH + 1)] = '0;
        end
      end
    end
    cyc++;
  end

  // Checking helpers and monitors (single process: the initial block)
  bit chk_en = 0;
  int tcyc = 0;
  int irq_cnt = 0;
  int wr_cnt = 0;
  int rd_t[$];
  logic [31:0] rd_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
  endtask

  task automatic compare_cycle();
    chk("bram_en", 32'(bram_en), 32'(e_en));
    chk("bram_we", 32'(bram_we), 32'(e_we));
    chk("irq", 32'(irq), 32'(e_irq));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("bank", 32'(bank), 32'(m_bank));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
    chk("overrun_cnt", 32'(overrun_cnt), 32'(m_over));
    if (e_en) chk("bram_addr", bram_addr, e_addr);
    if (e_en && e_we) chk("bram_din", bram_din, e_din);
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_cycle();
    if (bram_en && bram_we) wr_cnt++;
    if (bram_en && !bram_we) begin
      rd_t.push_back(tcyc);
      rd_a.push_back(bram_addr);
    end
    if (irq) irq_cnt++;
    tcyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] d);
    valid = 1'b1;
    datos = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic ps_release(input int w);
    rel_word = w;
    rel_req++;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before, irq_before, over_before, gap, last_v;
    bit hit99;

    // Reset
    wait_cycles(3);
    chk("reset_en", 32'(bram_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    chk_en = 1;
    wait_cycles(2);

    // Bank 0: samples 1..4, spaced 10 cycles
    run = 1'b1;
    wait_cycles(5);
    for (int k = 1; k <= 4; k++) begin
      send(32'(k));
      wait_cycles(9);
    end
    chk("b0_frame", 32'(frame_cnt), 32'd1);
    chk("b0_bank", 32'(bank), 32'd1);
    chk("b0_irqs", 32'(irq_cnt), 32'd1);
    chk("b0_flag", mem[0], 32'h8000_0001);
    for (int k = 1; k <= 4; k++) chk("b0_sample", mem[k], 32'(k));
    chk("model_frame_pin", 32'(m_frame), 32'd1);

    // Bank 1: samples 5..8
    for (int k = 5; k <= 8; k++) begin
      send(32'(k));
      wait_cycles(9);
    end
    chk("b1_flag", mem[5], 32'h8000_0002);
    for (int k = 6; k <= 9; k++) chk("b1_sample", mem[k], 32'(k - 1));
    chk("b1_bank", 32'(bank), 32'd0);

    // Bank 0 still owned by the PS: stall, poll, drop
    wr_before = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      send(32'hDEAD_0000 + 32'(k));
      wait_cycles(9);
    end
    chk("stall_over", 32'(overrun_cnt), 32'd3);
    chk("model_over_pin", 32'(m_over), 32'd3);
    chk("stall_no_writes", 32'(wr_cnt), 32'(wr_before));
    gap = rd_t[rd_t.size() - 1] - rd_t[rd_t.size() - 2];
    chk("poll_period", 32'(gap), 32'd6);
    chk("poll_addr", rd_a[rd_a.size() - 1], 32'd0);

    // PS releases bank 0; capture resumes at index 0
    ps_release(0);
    wait_cycles(8);
    send(32'd9);
    tick();
    chk("resume_addr4", mem[1], 32'd9);
    wait_cycles(8);
    send(32'd10);
    wait_cycles(9);

    // Abort mid-bank and restart at the same bank
    irq_before = irq_cnt;
    run = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    wait_cycles(5);
    chk("abort_no_irq", 32'(irq_cnt), 32'(irq_before));
    chk("abort_bank", 32'(bank), 32'd0);
    run = 1'b1;
    wait_cycles(5);
    send(32'd11);
    tick();
    chk("restart_addr4", mem[1], 32'd11);
    ps_release(5);
    wait_cycles(7);

    // Fill bank 0 and strobe during the FLAG cycle
    send(32'd12);
    wait_cycles(9);
    send(32'd13);
    wait_cycles(9);
    over_before = int'(overrun_cnt);
    send(32'd14);
    tick();
    send(32'd99);
    wait_cycles(9);
    chk("flagcyc_over", 32'(overrun_cnt), 32'(over_before + 1));
    chk("flagcyc_flag", mem[0], 32'h8000_0003);
    hit99 = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] == 32'd99) hit99 = 1;
    chk("flagcyc_not_written", 32'(hit99), 32'd0);
    send(32'd15);
    tick();
    chk("next_bank_idx0", mem[6], 32'd15);
    chk("irq_total", 32'(irq_cnt), 32'd3);
    wait_cycles(8);

    // Asynchronous reset during a sample write
    send(32'd16);
    chk_en = 0;
    chk("pre_reset_we", 32'(bram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_en", 32'(bram_en), 32'd0);
    chk("async_we", 32'(bram_we), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    run = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    chk_en = 1;
    tick();
    chk("post_reset_frame", 32'(frame_cnt), 32'd0);
    chk("post_reset_bank", 32'(bank), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("model_reset_pin", 32'(m_frame), 32'd0);

    // Randomized traffic with a PS that releases flags at random
    ps_random = 1;
    run = 1'b1;
    last_v = 100;
    for (int i = 0; i < 4000; i++) begin
      if (run && $urandom_range(0, 199) == 0 &&
          m_flag_at != cyc && !(m_cap && m_n == DEPTH)) begin
        run = 1'b0;
      end else if (!run && $urandom_range(0, 9) == 0) begin
        run = 1'b1;
      end
      if (last_v >= 4 && $urandom_range(0, 2) == 0) begin
        valid = 1'b1;
        datos = $urandom;
        last_v = 1;
      end else begin
        valid = 1'b0;
        last_v++;
      end
      tick();
    end
    valid = 1'b0;
    wait_cycles(4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
